// File: rtl/register_file_if.sv
// Commit, rename and operand-read bus between the reorder buffer/instruction unit (master) and the register file (slave).
// Pure wiring, no latency; no backpressure on this bus.
// Advancing is gated by readyIn on the register file itself.
interface register_file_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 regUpdateValid;
    logic [4:0]           regUpdateDest;
    logic [31:0]          regValue;
    logic [ROB_WIDTH-1:0] regUpdateRobId;

    logic                 renameValid;
    logic [4:0]           renameDest;
    logic [ROB_WIDTH-1:0] renameRobId;

    logic [4:0]           rs1;
    logic [31:0]          rs1Value;
    logic                 rs1Dirty;
    logic [ROB_WIDTH-1:0] rs1Dep;
    logic [4:0]           rs2;
    logic [31:0]          rs2Value;
    logic                 rs2Dirty;
    logic [ROB_WIDTH-1:0] rs2Dep;

    modport master (
        output regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output renameValid, renameDest, renameRobId,
        output rs1, rs2,
        input  rs1Value, rs1Dirty, rs1Dep, rs2Value, rs2Dirty, rs2Dep
    );

    modport slave (
        input  regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  renameValid, renameDest, renameRobId,
        input  rs1, rs2,
        output rs1Value, rs1Dirty, rs1Dep, rs2Value, rs2Dirty, rs2Dep
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register dirty bit and rename tag; REGFILE_BYPASS_EN forwards same-cycle commits to reads.
// Latency: reads combinational, commits/renames visible next cycle (commit same cycle with bypass).
// Backpressure: readyIn=0 freezes all state; held commits are idempotent when reapplied.
module register_file #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_COUNT = 32
) (
    input logic            clockIn,
    input logic            resetIn,
    input logic            readyIn,
    input logic            clearIn,
    register_file_if.slave rf
);
    logic [31:0]          values [REG_COUNT];
    logic [ROB_WIDTH-1:0] tags   [REG_COUNT];
    logic [REG_COUNT-1:0] dirty;

    logic commitHit;
    logic renameHit;

    assign commitHit = readyIn && rf.regUpdateValid && (rf.regUpdateDest != 5'd0);
    assign renameHit = readyIn && rf.renameValid && (rf.renameDest != 5'd0) && !clearIn;

    // Later assignments override earlier ones: clear and rename beat the commit's dirty clear.
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
            dirty <= '0;
        end else if (readyIn) begin
            if (commitHit) begin
                values[rf.regUpdateDest] <= rf.regValue;
                if (dirty[rf.regUpdateDest] && (tags[rf.regUpdateDest] == rf.regUpdateRobId))
                    dirty[rf.regUpdateDest] <= 1'b0;
            end
            if (clearIn) begin
                dirty <= '0;
            end else if (renameHit) begin
                dirty[rf.renameDest] <= 1'b1;
                tags[rf.renameDest]  <= rf.renameRobId;
            end
        end
    end

    always_comb begin
        rf.rs1Value = values[rf.rs1];
        rf.rs1Dirty = dirty[rf.rs1];
        rf.rs1Dep   = tags[rf.rs1];
`ifdef REGFILE_BYPASS_EN
        if (commitHit && (rf.regUpdateDest == rf.rs1)) begin
            rf.rs1Value = rf.regValue;
            if (tags[rf.rs1] == rf.regUpdateRobId)
                rf.rs1Dirty = 1'b0;
        end
`endif
        if (rf.rs1 == 5'd0) begin
            rf.rs1Value = '0;
            rf.rs1Dirty = 1'b0;
        end
    end

    always_comb begin
        rf.rs2Value = values[rf.rs2];
        rf.rs2Dirty = dirty[rf.rs2];
        rf.rs2Dep   = tags[rf.rs2];
`ifdef REGFILE_BYPASS_EN
        if (commitHit && (rf.regUpdateDest == rf.rs2)) begin
            rf.rs2Value = rf.regValue;
            if (tags[rf.rs2] == rf.regUpdateRobId)
                rf.rs2Dirty = 1'b0;
        end
`endif
        if (rf.rs2 == 5'd0) begin
            rf.rs2Value = '0;
            rf.rs2Dirty = 1'b0;
        end
    end
endmodule
